fetch_stage_unit: RTL and testbench

// Instruction-fetch front end that feeds the IF/ID pipeline register. Owns the fetch PC and talks
// to a variable-latency instruction memory over a req/ready + rvalid handshake, one request in flight.

---
 rtl/fetch_stage_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_stage_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_stage_unit
// Purpose  : IF front end - owns fetch PC, one-outstanding imem handshake,
//            small in-order {pc,instr} queue feeding the IF/ID register.
// Revision : 1.0
// ============================================================================
module fetch_stage_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int               PTR_W     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int               CNT_W     = $clog2(QDEPTH + 1);
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(QDEPTH - 1);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [31:0]        q_pc_q    [QDEPTH];
  logic [31:0]        q_pc_d    [QDEPTH];
  logic [31:0]        q_instr_q [QDEPTH];
  logic [31:0]        q_instr_d [QDEPTH];

  logic               not_empty;
  logic               not_full;
  logic               handshake;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty = (count_q != '0);
  assign not_full  = (count_q < DEPTH_C);

  // Issue is gated on free space, so a returning response always has a slot.
  assign imem_req  = rst_n & (state_q == ST_REQ) & not_full & ~redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign handshake = imem_req & imem_ready;

  assign push      = (state_q == ST_WAIT) & imem_rvalid & ~redirect_valid;
  assign if_valid  = not_empty & ~redirect_valid;
  assign pop       = if_valid & ~stall;

  assign if_pc     = not_empty ? q_pc_q[head_q]    : 32'h0000_0000;
  assign if_instr  = not_empty ? q_instr_q[head_q] : NOP_INSTR;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    q_pc_d     = q_pc_q;
    q_instr_d  = q_instr_q;

    if (handshake) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (push) begin
      q_pc_d[tail_q]    = req_pc_q;
      q_instr_d[tail_q] = imem_rdata;
      tail_d            = ptr_inc(tail_q);
    end

    if (pop) begin
      head_d = ptr_inc(head_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_REQ:  if (handshake)           state_d = ST_WAIT;
      ST_WAIT: if (imem_rvalid)         state_d = ST_REQ;
               else if (redirect_valid) state_d = ST_DROP;
      ST_DROP: if (imem_rvalid)         state_d = ST_REQ;
      default:                          state_d = ST_REQ;
    endcase

    // Redirect wins over everything: wrong-path entries and PC are discarded.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'd3;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      q_pc_q     <= q_pc_d;
      q_instr_q  <= q_instr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for fetch_stage_unit: randomized memory/stall/redirect traffic against a
// queue-based reference model, plus directed scenarios with literal expectations.
module tb_fetch_stage_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  fetch_stage_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_discard;
  logic [63:0] m_q[$];

  function automatic void model_reset();
    m_fetch_pc = RESET_PC;
    m_req_pc   = '0;
    m_out      = 1'b0;
    m_discard  = 1'b0;
    m_q.delete();
  endfunction

  function automatic bit exp_req();
    return rst_n && !m_out && (m_q.size() < QDEPTH) && !redirect_valid;
  endfunction

  // Advance the model by one clock using the inputs held during the last cycle.
  function automatic void model_update();
    bit hs;
    hs = exp_req() && imem_ready;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_fetch_pc = redirect_pc & ~32'd3;
      if (m_out) begin
        if (imem_rvalid) begin m_out = 1'b0; m_discard = 1'b0; end
        else m_discard = 1'b1;
      end
    end else begin
      if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
      if (m_out && imem_rvalid) begin
        if (!m_discard) m_q.push_back({m_req_pc, imem_rdata});
        m_out = 1'b0;
        m_discard = 1'b0;
      end
      if (hs) begin
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_out      = 1'b1;
      end
    end
  endfunction

  // ---------------- memory environment ----------------
  int          p_ready = 100, p_stall = 0, p_redir = 0, p_spur = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          rnd_data = 1'b0;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [31:0] pdata = '0;
  int          hs_count = 0;

  task automatic apply(input bit stl, input bit rdv, input logic [31:0] rpc,
                       input bit nv, input logic [31:0] nd);
    stall          = stl;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    imem_ready     = ($urandom_range(99) < p_ready);
    imem_rvalid    = nv;
    imem_rdata     = nd;
    #1;
    if (imem_req && imem_ready) begin
      hs_count++;
      pend  = 1'b1;
      lat   = $urandom_range(lat_hi, lat_lo);
      pdata = rnd_data ? $urandom : (imem_addr | 32'h0000_0100);
    end
  endtask

  task automatic step(input bit stl, input bit rdv, input logic [31:0] rpc);
    bit          nv;
    logic [31:0] nd;
    @(posedge clk);
    model_update();
    nv = 1'b0;
    nd = $urandom;
    if (pend) begin
      if (lat <= 1) begin nv = 1'b1; nd = pdata; pend = 1'b0; end
      else lat--;
    end else if ($urandom_range(99) < p_spur) begin
      nv = 1'b1;
    end
    #1;
    apply(stl, rdv, rpc, nv, nd);
  endtask

  // ---------------- observation for literal checks ----------------
  int          cyc = 0;
  int          first_req = -1;
  int          first_valid = -1;
  logic [63:0] popped[$];

  task automatic do_reset(input bit stl);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    pend = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    first_req = -1;
    first_valid = -1;
    popped.delete();
    apply(stl, 1'b0, 32'h0, 1'b0, $urandom);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [63:0] h;
    chk("imem_req", 32'(imem_req), 32'(exp_req()));
    chk("imem_addr", imem_addr, m_fetch_pc);
    chk("if_valid", 32'(if_valid), 32'(m_q.size() != 0 && !redirect_valid));
    if (m_q.size() == 0) begin
      chk("if_pc_empty", if_pc, 32'h0);
      chk("if_instr_empty", if_instr, NOP);
    end else if (!redirect_valid) begin
      h = m_q[0];
      chk("if_pc", if_pc, h[63:32]);
      chk("if_instr", if_instr, h[31:0]);
    end
    if (imem_req && first_req < 0) first_req = cyc;
    if (if_valid && first_valid < 0) first_valid = cyc;
    if (if_valid && !stall) popped.push_back({if_pc, if_instr});
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          found;
    int          hs0;
    logic [63:0] e;
    model_reset();

    // Reset state while rst_n is low
    #2;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_imem_addr", imem_addr, RESET_PC);

    // 1: in-order stream, 2-cycle latency to first if_valid
    do_reset(1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0);
    chk("t1_latency", 32'(first_valid - first_req), 32'd2);
    chk("t1_pops", 32'(popped.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      e = (popped.size() > i) ? popped[i] : 64'h0;
      chk("t1_pc", e[63:32], 32'(4 * i));
      chk("t1_instr", e[31:0], 32'h100 + 32'(4 * i));
    end

    // 2: stall from start fills the queue, then drains on consecutive cycles
    do_reset(1'b1);
    repeat (8) step(1'b1, 1'b0, 32'h0);
    chk("t2_req_off", 32'(imem_req), 32'd0);
    chk("t2_valid", 32'(if_valid), 32'd1);
    chk("t2_pc_held", if_pc, 32'h0);
    chk("t2_model_depth", 32'(m_q.size()), 32'd2);
    step(1'b0, 1'b0, 32'h0);
    chk("t2_pop0", if_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t2_pop1", if_pc, 32'h4);
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h8);

    // 3: redirect while waiting on a slow response
    lat_lo = 3; lat_hi = 3;
    do_reset(1'b0);
    step(1'b0, 1'b1, 32'h42);
    chk("t3_req_masked", 32'(imem_req), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (imem_req) found = 1'b1;
    end
    chk("t3_req_seen", 32'(found), 32'd1);
    chk("t3_addr", imem_addr, 32'h40);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (if_valid) found = 1'b1;
    end
    chk("t3_valid_seen", 32'(found), 32'd1);
    chk("t3_if_pc", if_pc, 32'h40);
    chk("t3_if_instr", if_instr, 32'h140);

    // 4: redirect coincident with the response
    lat_lo = 1; lat_hi = 1;
    do_reset(1'b0);
    step(1'b0, 1'b1, 32'h80);
    chk("t4_rvalid_here", 32'(imem_rvalid), 32'd1);
    chk("t4_valid_same", 32'(if_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("t4_not_pushed", 32'(if_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h80);

    // 5: memory not ready for three cycles
    p_ready = 0;
    do_reset(1'b0);
    hs0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      chk("t5_req_hold", 32'(imem_req), 32'd1);
      chk("t5_addr_hold", imem_addr, RESET_PC);
      if (i < 2) step(1'b0, 1'b0, 32'h0);
    end
    p_ready = 100;
    step(1'b0, 1'b0, 32'h0);
    chk("t5_accept", 32'(hs_count - hs0), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("t5_once_req", 32'(imem_req), 32'd0);
    chk("t5_once_cnt", 32'(hs_count - hs0), 32'd1);

    // 6: asynchronous reset mid-WAIT with one queued entry; late response ignored
    do_reset(1'b1);
    step(1'b1, 1'b0, 32'h0);
    lat_lo = 3; lat_hi = 3;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("t6_queued", 32'(if_valid), 32'd1);
    p_ready = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid_drop", 32'(if_valid), 32'd0);
    chk("t6_req_drop", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("t6_restart_addr", imem_addr, RESET_PC);
    step(1'b0, 1'b0, 32'h0);
    chk("t6_late_rvalid", 32'(imem_rvalid), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("t6_ignored", 32'(if_valid), 32'd0);
    chk("t6_still_req", 32'(imem_req), 32'd1);
    p_ready = 100;
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // Randomized traffic against the model
    rnd_data = 1'b1;
    p_ready = 70; p_stall = 30; p_redir = 5; p_spur = 5;
    lat_lo = 1; lat_hi = 3;
    for (int blk = 0; blk < 6; blk++) begin
      do_reset(1'b0);
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(99) < p_stall, $urandom_range(99) < p_redir, $urandom);
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
